// File: rtl/bb_pkg.sv
// ============================================================================
// bb_pkg: shared constants, FSM state type and helpers for the pattern generator
// Revision: 1.0
// ============================================================================
`default_nettype none

package bb_pkg;

    localparam logic [2:0] C_ACT_WALK   = 3'd0;
    localparam logic [2:0] C_ACT_SINGLE = 3'd1;
    localparam logic [2:0] C_ACT_DOUBLE = 3'd2;
    localparam logic [2:0] C_ACT_TRIPLE = 3'd3;
    localparam logic [2:0] C_ACT_HR     = 3'd4;
    localparam logic [2:0] C_ACT_BUNT   = 3'd5;
    localparam logic [2:0] C_ACT_GROUND = 3'd6;
    localparam logic [2:0] C_ACT_FLY    = 3'd7;

    localparam logic [1:0] C_RES_A_WINS = 2'd0;
    localparam logic [1:0] C_RES_B_WINS = 2'd1;
    localparam logic [1:0] C_RES_DRAW   = 2'd2;

    localparam logic [15:0] C_DEFAULT_SEED = 16'hACE1;
    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11 (taps on bits 0,2,3,5)
    localparam logic [15:0] C_LFSR_TAPS    = 16'h002D;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {^(s & C_LFSR_TAPS), s[15:1]};
    endfunction

    function automatic logic [2:0] legalize(input logic [2:0] act, input logic [1:0] outs);
        return (act == C_ACT_BUNT && outs == 2'd2) ? C_ACT_FLY : act;
    endfunction

    function automatic logic [1:0] result_of(input logic [7:0] a, input logic [7:0] b);
        if (a > b)      return C_RES_A_WINS;
        else if (b > a) return C_RES_B_WINS;
        else            return C_RES_DRAW;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bb_play_model.sv
// ============================================================================
// bb_play_model: combinational base/out/run transition for one batted action
// Revision: 1.0
// ============================================================================
`default_nettype none

module bb_play_model
    import bb_pkg::*;
(
    input  logic [2:0] bases,       // [0]=1st, [1]=2nd, [2]=3rd
    input  logic [1:0] outs,
    input  logic [2:0] action,
    output logic [2:0] next_bases,
    output logic [1:0] next_outs,
    output logic [2:0] runs,
    output logic       half_end
);

    logic [2:0] w_on_base;
    assign w_on_base = 3'(bases[0]) + 3'(bases[1]) + 3'(bases[2]);

    always_comb begin
        next_bases = bases;
        next_outs  = outs;
        runs       = 3'd0;
        half_end   = 1'b0;
        case (action)
            C_ACT_WALK: begin
                if (!bases[0])      next_bases = bases | 3'b001;
                else if (!bases[1]) next_bases = bases | 3'b011;
                else begin
                    next_bases = 3'b111;
                    runs       = 3'(bases[2]);
                end
            end
            C_ACT_SINGLE: begin
                if (outs == 2'd2) begin
                    next_bases = {bases[0], 1'b0, 1'b1};
                    runs       = 3'(bases[1]) + 3'(bases[2]);
                end else begin
                    next_bases = {bases[1], bases[0], 1'b1};
                    runs       = 3'(bases[2]);
                end
            end
            C_ACT_DOUBLE: begin
                if (outs == 2'd2) begin
                    next_bases = 3'b010;
                    runs       = w_on_base;
                end else begin
                    next_bases = {bases[0], 1'b1, 1'b0};
                    runs       = 3'(bases[1]) + 3'(bases[2]);
                end
            end
            C_ACT_TRIPLE: begin
                next_bases = 3'b100;
                runs       = w_on_base;
            end
            C_ACT_HR: begin
                next_bases = 3'b000;
                runs       = w_on_base + 3'd1;
            end
            C_ACT_BUNT: begin
                // A bunt at two outs never reaches here legalized; treat it as the third out
                if (outs == 2'd2) half_end = 1'b1;
                else begin
                    next_outs  = outs + 2'd1;
                    next_bases = {bases[1], bases[0], 1'b0};
                    runs       = 3'(bases[2]);
                end
            end
            C_ACT_GROUND: begin
                if (outs == 2'd0 || (outs == 2'd1 && !bases[0])) begin
                    next_outs  = (outs == 2'd0 && !bases[0]) ? 2'd1 : 2'd2;
                    next_bases = {bases[1], 2'b00};
                    runs       = 3'(bases[2]);
                end else begin
                    half_end = 1'b1;
                end
            end
            default: begin
                if (outs == 2'd2) half_end = 1'b1;
                else begin
                    next_outs  = outs + 2'd1;
                    next_bases = {1'b0, bases[1], bases[0]};
                    runs       = 3'(bases[2]);
                end
            end
        endcase
        if (half_end) begin
            next_bases = 3'b000;
            next_outs  = 2'd0;
            runs       = 3'd0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bb_pattern_gen.sv
// ============================================================================
// bb_pattern_gen: contiguous play-by-play stimulus with self-scored expectations
// Revision: 1.0
// ============================================================================
`default_nettype none

module bb_pattern_gen
    import bb_pkg::*;
#(
    parameter logic [15:0] DEFAULT_SEED = C_DEFAULT_SEED,
    parameter int          NUM_INNINGS  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] seed,
    input  logic        script_en,
    input  logic [2:0]  script_action,
    output logic        busy,
    output logic        out_valid,
    output logic [1:0]  inning,
    output logic        half,
    output logic [2:0]  action,
    output logic        done,
    output logic [7:0]  exp_score_A,
    output logic [7:0]  exp_score_B,
    output logic [1:0]  exp_result
);

    state_t      r_state;
    logic [15:0] r_lfsr;
    logic        r_script;
    logic [2:0]  r_bases;
    logic [1:0]  r_outs;

    logic [2:0]  w_next_bases;
    logic [1:0]  w_next_outs;
    logic [2:0]  w_runs;
    logic        w_half_end;
    logic [7:0]  w_score_a;
    logic [7:0]  w_score_b;
    logic        w_game_end;
    logic [15:0] w_seed_eff;
    logic [2:0]  w_next_act;
    logic [2:0]  w_first_act;

    bb_play_model u_model (
        .bases      (r_bases),
        .outs       (r_outs),
        .action     (action),
        .next_bases (w_next_bases),
        .next_outs  (w_next_outs),
        .runs       (w_runs),
        .half_end   (w_half_end)
    );

    assign w_score_a  = exp_score_A + (half ? 8'd0 : {5'd0, w_runs});
    assign w_score_b  = exp_score_B + (half ? {5'd0, w_runs} : 8'd0);
    // Top of the last inning ends the game early only if the home side already leads
    assign w_game_end = w_half_end && (inning == 2'(NUM_INNINGS)) &&
                        (half || (w_score_b > w_score_a));
    assign w_seed_eff  = (seed == 16'd0) ? DEFAULT_SEED : seed;
    assign w_first_act = script_en ? script_action : w_seed_eff[2:0];
    assign w_next_act  = legalize(r_script ? script_action : r_lfsr[2:0], w_next_outs);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_lfsr      <= 16'd0;
            r_script    <= 1'b0;
            r_bases     <= 3'd0;
            r_outs      <= 2'd0;
            busy        <= 1'b0;
            out_valid   <= 1'b0;
            inning      <= 2'd0;
            half        <= 1'b0;
            action      <= 3'd0;
            done        <= 1'b0;
            exp_score_A <= 8'd0;
            exp_score_B <= 8'd0;
            exp_result  <= 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state     <= ST_PLAY;
                        r_lfsr      <= lfsr_step(w_seed_eff);
                        r_script    <= script_en;
                        r_bases     <= 3'd0;
                        r_outs      <= 2'd0;
                        busy        <= 1'b1;
                        out_valid   <= 1'b1;
                        inning      <= 2'd1;
                        half        <= 1'b0;
                        action      <= legalize(w_first_act, 2'd0);
                        exp_score_A <= 8'd0;
                        exp_score_B <= 8'd0;
                        exp_result  <= 2'd0;
                    end
                end
                ST_PLAY: begin
                    r_bases     <= w_next_bases;
                    r_outs      <= w_next_outs;
                    exp_score_A <= w_score_a;
                    exp_score_B <= w_score_b;
                    if (w_game_end) begin
                        r_state    <= ST_DONE;
                        out_valid  <= 1'b0;
                        done       <= 1'b1;
                        exp_result <= result_of(w_score_a, w_score_b);
                    end else begin
                        action <= w_next_act;
                        r_lfsr <= lfsr_step(r_lfsr);
                        if (w_half_end) begin
                            half <= ~half;
                            if (half) inning <= inning + 2'd1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bb_pattern_gen.sv
// ============================================================================
// tb_bb_pattern_gen: directed scripted games with hand-computed expectations
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bb_pattern_gen;
    import bb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] seed = 16'd0;
    logic        script_en = 1'b0;
    logic [2:0]  script_action = 3'd0;
    logic        busy, out_valid, half, done;
    logic [1:0]  inning, exp_result;
    logic [2:0]  action;
    logic [7:0]  exp_score_A, exp_score_B;

    bb_pattern_gen #(.DEFAULT_SEED(16'hACE1), .NUM_INNINGS(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .seed          (seed),
        .script_en     (script_en),
        .script_action (script_action),
        .busy          (busy),
        .out_valid     (out_valid),
        .inning        (inning),
        .half          (half),
        .action        (action),
        .done          (done),
        .exp_score_A   (exp_score_A),
        .exp_score_B   (exp_score_B),
        .exp_result    (exp_result)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [2:0] script_q [$];
    logic [2:0] log_act  [64];
    logic       log_half [64];
    logic [1:0] log_inn  [64];
    int         n_valid;
    logic       gap, got_done, any_flag;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Plays script_q (fly balls beyond its end); pulses start when poke actions were seen
    task automatic run_game(input int poke, input string tag);
        n_valid  = 0;
        gap      = 1'b0;
        got_done = 1'b0;
        @(negedge clk);
        start         = 1'b1;
        script_en     = 1'b1;
        seed          = 16'h1234;
        script_action = (script_q.size() > 0) ? script_q[0] : C_ACT_FLY;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 200 && !got_done; cyc++) begin
            if (out_valid) begin
                if (n_valid < 64) begin
                    log_act[n_valid]  = action;
                    log_half[n_valid] = half;
                    log_inn[n_valid]  = inning;
                end
                n_valid++;
                script_action = (n_valid < script_q.size()) ? script_q[n_valid] : C_ACT_FLY;
                start = (n_valid == poke);
            end else if (done) begin
                got_done = 1'b1;
            end else begin
                gap = 1'b1;
            end
            if (!got_done) begin
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, got_done, 1);
        check({tag, "_no_gap"}, gap, 0);
        check({tag, "_busy_at_done"}, busy, 1);
        // A start during the done cycle must not be accepted
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy_fall"}, busy, 0);
        check({tag, "_done_pulse"}, done, 0);
        @(posedge clk); #1;
        check({tag, "_no_restart"}, out_valid, 0);
    endtask

    initial begin
        #1;
        check("rst_async_valid", out_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", {busy, out_valid, inning, half, action, done}, 0);
        check("rst_scores", {exp_score_A, exp_score_B, exp_result}, 0);
        @(negedge clk);
        rst = 1'b0;
        any_flag = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            any_flag = any_flag | out_valid | busy;
        end
        check("idle_after_rst", any_flag, 0);

        // Two home runs in the top of the 1st, fly balls everywhere else
        script_q = '{C_ACT_HR, C_ACT_HR, C_ACT_FLY, C_ACT_FLY, C_ACT_FLY};
        run_game(-1, "g1");
        check("g1_count", n_valid, 20);
        check("g1_first_inning", log_inn[0], 1);
        check("g1_first_half", log_half[0], 0);
        check("g1_score_A", exp_score_A, 2);
        check("g1_score_B", exp_score_B, 0);
        check("g1_result", exp_result, C_RES_A_WINS);
        check("g1_last_half", log_half[19], 1);
        check("g1_held_A", exp_score_A, 2);

        // Home run in the bottom of the 1st; bottom of the 3rd is skipped
        script_q = '{C_ACT_FLY, C_ACT_FLY, C_ACT_FLY, C_ACT_HR};
        run_game(-1, "g2");
        check("g2_count", n_valid, 16);
        check("g2_last_inning", log_inn[15], 3);
        check("g2_last_half", log_half[15], 0);
        check("g2_score_A", exp_score_A, 0);
        check("g2_score_B", exp_score_B, 1);
        check("g2_result", exp_result, C_RES_B_WINS);

        // Bases loaded then two ground balls: one run, runner stranded on 3rd
        script_q = '{C_ACT_WALK, C_ACT_WALK, C_ACT_WALK, C_ACT_GROUND, C_ACT_GROUND};
        run_game(-1, "g3");
        check("g3_count", n_valid, 20);
        check("g3_act4", log_act[4], C_ACT_GROUND);
        check("g3_half_at_act4", log_half[4], 0);
        check("g3_half_at_act5", log_half[5], 1);
        check("g3_score_A", exp_score_A, 1);
        check("g3_score_B", exp_score_B, 0);
        check("g3_result", exp_result, C_RES_A_WINS);

        // Bunt at two outs becomes a fly ball; start pulsed mid-game is ignored
        script_q = '{C_ACT_FLY, C_ACT_FLY, C_ACT_BUNT};
        run_game(5, "g4");
        check("g4_count", n_valid, 18);
        check("g4_act0", log_act[0], C_ACT_FLY);
        check("g4_act1", log_act[1], C_ACT_FLY);
        check("g4_act2", log_act[2], C_ACT_FLY);
        check("g4_half_act2", log_half[2], 0);
        check("g4_half_act3", log_half[3], 1);
        check("g4_inning_act6", log_inn[6], 2);
        check("g4_result", exp_result, C_RES_DRAW);

        // LFSR mode with zero seed falls back to 16'hACE1, then an async reset mid-game
        @(negedge clk);
        start     = 1'b1;
        script_en = 1'b0;
        seed      = 16'd0;
        @(posedge clk); #1;
        start = 1'b0;
        check("lfsr_valid", out_valid, 1);
        check("lfsr_act0", action, C_ACT_SINGLE);
        check("lfsr_inning", inning, 1);
        @(posedge clk); #1;
        check("lfsr_act1", action, C_ACT_WALK);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_inning", inning, 0);
        @(negedge clk);
        rst = 1'b0;
        any_flag = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            any_flag = any_flag | done | out_valid;
        end
        check("midrst_no_done", any_flag, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
